// File: rtl/audio_source_arbiter_if.sv
// Bundle between the four audio sources and the output arbiter.
// The arbiter takes the slave view; the source/test side takes the master view.
interface audio_source_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [2:0] audioSelect;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  audioSelect,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output audioSelect,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/audio_source_arbiter.sv
// Round-robin owner of the shared PWM audio output with a muted guard gap
// between grants and a per-grant play-time limit.
module audio_source_arbiter #(
  parameter int unsigned GAP_CYCLES      = 1000,
  parameter int unsigned MAX_PLAY_CYCLES = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  audio_source_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(MAX_PLAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] play_cnt_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [2:0]       sel_q;
  logic [3:0]       grant_q;
  logic             busy_q;
  logic             timeout_q;

  // Requests rotated so that bit 0 is the source just after the last served one.
  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = bus.req[ptr_q + 2'(gi + 1)];
    end
  endgenerate

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_off = 2'(k);
      end
    end
  end

  assign win_idx = ptr_q + 2'd1 + win_off;

  // While playing, ptr_q already names the current owner.
  logic owner_done;
  logic owner_gone;
  logic play_limit;

  assign owner_done = bus.done[ptr_q];
  assign owner_gone = ~bus.req[ptr_q];
  assign play_limit = (play_cnt_q == PLAY_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd3;
      play_cnt_q <= '0;
      gap_cnt_q  <= '0;
      sel_q      <= 3'd0;
      grant_q    <= 4'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req != 4'd0) begin
            state_q    <= S_PLAY;
            ptr_q      <= win_idx;
            play_cnt_q <= '0;
            sel_q      <= {1'b0, win_idx} + 3'd1;
            grant_q    <= 4'b0001 << win_idx;
            busy_q     <= 1'b1;
          end
        end

        S_PLAY: begin
          if (owner_done || owner_gone || play_limit) begin
            state_q   <= S_GAP;
            gap_cnt_q <= '0;
            sel_q     <= 3'd0;
            grant_q   <= 4'd0;
            // Only a pure limit expiry counts as a timeout.
            timeout_q <= play_limit && !owner_done && !owner_gone;
          end else begin
            play_cnt_q <= play_cnt_q + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          sel_q   <= 3'd0;
          grant_q <= 4'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.audioSelect = sel_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_audio_source_arbiter.sv
// Directed bench for audio_source_arbiter with a short gap and play limit.
module tb_audio_source_arbiter;

  localparam int GAP = 4;
  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int n;
  int m;
  int exp_src [5] = '{1, 2, 3, 4, 1};

  audio_source_arbiter_if bus ();

  audio_source_arbiter #(
    .GAP_CYCLES     (GAP),
    .MAX_PLAY_CYCLES(MAXP),
    .CNT_W          (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Checks select, the matching one-hot grant, and busy.
  task automatic chk_out(input string tag, input int sel, input logic busy_e);
    logic [3:0] g;
    g = (sel == 0) ? 4'd0 : (4'b0001 << (sel - 1));
    chk({tag, ".sel"}, 32'(bus.audioSelect), 32'(sel));
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy_e));
  endtask

  // Counts muted cycles, starting with the current one, until a grant appears.
  task automatic count_muted(output int cnt);
    cnt = 1;
    while (bus.audioSelect == 3'd0 && cnt < 50) begin
      step();
      if (bus.audioSelect == 3'd0) cnt++;
    end
  endtask

  initial begin
    bus.req  = 4'd0;
    bus.done = 4'd0;

    // 1: reset and idle
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk_out("idle", 0, 1'b0);
      chk("idle.timeout", 32'(bus.timeout), 32'd0);
      step();
    end

    // 2: source 1 first, then gap, then source 3
    bus.req = 4'b0101;
    step();
    chk_out("t2.grant1", 1, 1'b1);
    step();
    bus.done = 4'b0001;
    step();
    bus.done = 4'b0000;
    chk_out("t2.gap", 0, 1'b1);
    count_muted(m);
    chk("t2.muted", 32'(m), 32'(GAP + 1));
    chk_out("t2.grant3", 3, 1'b1);
    bus.req = 4'b0000;
    step();
    chk_out("t2.drop", 0, 1'b1);
    repeat (6) step();
    chk_out("t2.idle", 0, 1'b0);

    // 3: full rotation after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("t3.g%0d", i), exp_src[i], 1'b1);
      step();
      bus.done = 4'b0001 << (exp_src[i] - 1);
      if (i == 4) bus.req = 4'b0000;
      step();
      bus.done = 4'b0000;
      chk_out($sformatf("t3.end%0d", i), 0, 1'b1);
      if (i < 4) begin
        count_muted(m);
        chk($sformatf("t3.muted%0d", i), 32'(m), 32'(GAP + 1));
      end
    end
    repeat (6) step();
    chk_out("t3.idle", 0, 1'b0);

    // 4: lone source 2 hits the play limit
    bus.req = 4'b0010;
    step();
    chk_out("t4.grant", 2, 1'b1);
    n = 1;
    while (bus.audioSelect == 3'd2 && n < 50) begin
      step();
      if (bus.audioSelect == 3'd2) n++;
    end
    chk("t4.play_len", 32'(n), 32'(MAXP));
    chk_out("t4.end", 0, 1'b1);
    chk("t4.timeout_hi", 32'(bus.timeout), 32'd1);
    step();
    chk("t4.timeout_lo", 32'(bus.timeout), 32'd0);
    count_muted(m);
    chk("t4.muted", 32'(m + 1), 32'(GAP + 1));
    chk_out("t4.regrant", 2, 1'b1);
    // done coinciding with the limit suppresses timeout
    repeat (7) step();
    chk_out("t4.last", 2, 1'b1);
    bus.done = 4'b0010;
    step();
    bus.done = 4'b0000;
    chk_out("t4.coinc", 0, 1'b1);
    chk("t4.coinc_to", 32'(bus.timeout), 32'd0);
    bus.req = 4'b0000;
    repeat (6) step();
    chk_out("t4.idle", 0, 1'b0);

    // 5: no preemption, foreign done ignored, then drop
    bus.req = 4'b0100;
    step();
    chk_out("t5.grant3", 3, 1'b1);
    bus.done = 4'b0001;
    bus.req = 4'b1100;
    step();
    bus.done = 4'b0000;
    chk_out("t5.hold1", 3, 1'b1);
    step();
    chk_out("t5.hold2", 3, 1'b1);
    bus.req = 4'b1000;
    step();
    chk_out("t5.drop", 0, 1'b1);
    chk("t5.drop_to", 32'(bus.timeout), 32'd0);
    count_muted(m);
    chk("t5.muted", 32'(m), 32'(GAP + 1));
    chk_out("t5.grant4", 4, 1'b1);

    // 6: reset in PLAY, in GAP, and at the limit edge
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("t6.rst_play", 0, 1'b0);
    chk("t6.rst_play_to", 32'(bus.timeout), 32'd0);
    step();
    chk_out("t6.after_play", 4, 1'b1);
    bus.done = 4'b1000;
    step();
    bus.done = 4'b0000;
    chk_out("t6.gap", 0, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("t6.rst_gap", 0, 1'b0);
    step();
    chk_out("t6.after_gap", 4, 1'b1);
    repeat (7) step();
    chk_out("t6.last", 4, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b0000;
    chk_out("t6.rst_limit", 0, 1'b0);
    chk("t6.rst_limit_to", 32'(bus.timeout), 32'd0);
    step();
    chk_out("t6.final", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
